// File: rtl/mem_arbiter.sv
// mem_arbiter: arbitrates one shared line-wide memory port between an I-cache (line fills)
// and a D-cache (line fills and write-backs).
//
// Ports:
//   clk, rst                      single clock, synchronous active-high reset
//   i_mem_read/i_mem_addr         I-cache fill request and line address
//   i_mem_rdata/i_mem_ready       I-cache returned line and one-cycle completion pulse
//   d_mem_read/d_mem_write        D-cache fill / write-back request
//   d_mem_addr/d_mem_wdata        D-cache line address and write-back data
//   d_mem_rdata/d_mem_ready       D-cache returned line and one-cycle completion pulse
//   mem_read/mem_write            shared-memory strobes (never both, only while serving)
//   mem_addr/mem_wdata            shared-memory address and write data
//   mem_rdata/mem_ready           shared-memory read data and completion
//
// D has priority, but after STARVE_LIM consecutive D grants with I waiting, I wins once.

module mem_arbiter #(
    parameter int unsigned ADDR_W     = 28,
    parameter int unsigned DATA_W     = 128,
    parameter int unsigned STARVE_LIM = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_mem_read,
    input  logic [ADDR_W-1:0] i_mem_addr,
    output logic [DATA_W-1:0] i_mem_rdata,
    output logic              i_mem_ready,
    input  logic              d_mem_read,
    input  logic              d_mem_write,
    input  logic [ADDR_W-1:0] d_mem_addr,
    input  logic [DATA_W-1:0] d_mem_wdata,
    output logic [DATA_W-1:0] d_mem_rdata,
    output logic              d_mem_ready,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready
);

    localparam int unsigned CntW = (STARVE_LIM > 0) ? $clog2(STARVE_LIM + 1) : 1;
    localparam logic [CntW-1:0] StarveLim = CntW'(STARVE_LIM);

    typedef enum logic [1:0] {
        StIdle,
        StServeI,
        StServeD,
        StResp
    } state_e;

    state_e            state_q, state_d;
    logic              owner_q, owner_d;   // 1: D-cache owns the current transfer
    logic              op_we_q, op_we_d;   // 1: current transfer is a write-back
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] i_rdata_q, i_rdata_d;
    logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
    logic [CntW-1:0]   starve_q, starve_d;

    logic d_req;
    logic i_wins;
    logic serving;

    assign d_req   = d_mem_read | d_mem_write;
    // I wins when alone, or when D has been favoured STARVE_LIM times in a row.
    assign i_wins  = i_mem_read & (~d_req | (starve_q == StarveLim));
    assign serving = (state_q == StServeI) || (state_q == StServeD);

    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        op_we_d   = op_we_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        i_rdata_d = i_rdata_q;
        d_rdata_d = d_rdata_q;
        starve_d  = starve_q;

        unique case (state_q)
            StIdle: begin
                if (!i_mem_read) begin
                    starve_d = '0;
                end
                if (i_wins) begin
                    state_d  = StServeI;
                    owner_d  = 1'b0;
                    op_we_d  = 1'b0;
                    addr_d   = i_mem_addr;
                    starve_d = '0;
                end else if (d_req) begin
                    state_d = StServeD;
                    owner_d = 1'b1;
                    // A simultaneous read stays pending behind the write-back.
                    op_we_d = d_mem_write;
                    addr_d  = d_mem_addr;
                    if (d_mem_write) begin
                        wdata_d = d_mem_wdata;
                    end
                    if (i_mem_read && (starve_q != StarveLim)) begin
                        starve_d = starve_q + CntW'(1);
                    end
                end
            end
            StServeI, StServeD: begin
                if (mem_ready) begin
                    state_d = StResp;
                    if (!op_we_q) begin
                        if (owner_q) begin
                            d_rdata_d = mem_rdata;
                        end else begin
                            i_rdata_d = mem_rdata;
                        end
                    end
                end
            end
            StResp: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            owner_q   <= 1'b0;
            op_we_q   <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            i_rdata_q <= '0;
            d_rdata_q <= '0;
            starve_q  <= '0;
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            op_we_q   <= op_we_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            i_rdata_q <= i_rdata_d;
            d_rdata_q <= d_rdata_d;
            starve_q  <= starve_d;
        end
    end

    // Memory side is driven purely from the latched transfer registers.
    assign mem_read    = serving & ~op_we_q;
    assign mem_write   = serving & op_we_q;
    assign mem_addr    = addr_q;
    assign mem_wdata   = wdata_q;

    assign i_mem_ready = (state_q == StResp) & ~owner_q;
    assign d_mem_ready = (state_q == StResp) & owner_q;
    assign i_mem_rdata = i_rdata_q;
    assign d_mem_rdata = d_rdata_q;

endmodule
